uart_transmitter_fifo: RTL and testbench

//  Parametrised UART serialiser: configurable data width, parity, stop bits, with TX FIFO.

---
 rtl/uart_transmitter_fifo.sv | 124 ++++++++++++
 tb/tb_uart_transmitter_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_fifo.sv
// UART serialiser with configurable framing and a TX FIFO; queued words go out
// back-to-back with no idle gap between frames.
module uart_transmitter_fifo #(
    parameter int CLOCK_FREQ = 33_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_BITS-1:0]              data_in,
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    output logic                              serial_out,
    output logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int BCW = $clog2(SYMBOL_EDGE_TIME);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state, state_next;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_bit;
    logic [BCW-1:0]         baud_cnt;
    logic [3:0]             bit_cnt;
    logic                   sym_edge;
    logic                   push, pop;
    logic                   line;

    assign data_in_ready = !reset && (fifo_count != CW'(FIFO_DEPTH));
    assign push          = data_in_valid && data_in_ready;
    assign sym_edge      = (baud_cnt == BCW'(SYMBOL_EDGE_TIME - 1));
    assign tx_busy       = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        line       = 1'b1;
        unique case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                line = 1'b0;
                if (sym_edge) state_next = DATA;
            end
            DATA: begin
                line = shift_reg[0];
                if (sym_edge && bit_cnt == 4'(DATA_BITS - 1))
                    state_next = (PARITY != 0) ? PAR : STOP;
            end
            PAR: begin
                line = parity_bit;
                if (sym_edge) state_next = STOP;
            end
            STOP: begin
                // last stop edge chains straight into the next frame when words are waiting
                if (sym_edge && bit_cnt == 4'(STOP_BITS - 1)) begin
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serial_out <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            serial_out <= line;

            if (state == IDLE || sym_edge) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + 1'b1;

            if (sym_edge && (state == DATA || state == STOP))
                bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;

            if (pop) begin
                shift_reg  <= mem[rd_ptr];
                parity_bit <= (PARITY == 2) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
            end else if (state == DATA && sym_edge) begin
                shift_reg  <= shift_reg >> 1;
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_transmitter_fifo.sv
// Bench for uart_transmitter_fifo: four framing variants against a queue/timer
// line model, plus literal bit-centre and latency expectations.
module tb_uart_transmitter_fifo;
    localparam int T = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [7:0] din [4];
    logic [3:0] rdy, ser, bsy;
    logic [3:0] cnt [4];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0 8N1, dut1 8E1, dut2 8O1, dut3 7N2
    uart_transmitter_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                            .STOP_BITS(1), .FIFO_DEPTH(8)) u0 (
        .clk(clk), .reset(rst), .data_in(din[0]), .data_in_valid(vld[0]),
        .data_in_ready(rdy[0]), .serial_out(ser[0]), .tx_busy(bsy[0]), .fifo_count(cnt[0]));
    uart_transmitter_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1),
                            .STOP_BITS(1), .FIFO_DEPTH(8)) u1 (
        .clk(clk), .reset(rst), .data_in(din[1]), .data_in_valid(vld[1]),
        .data_in_ready(rdy[1]), .serial_out(ser[1]), .tx_busy(bsy[1]), .fifo_count(cnt[1]));
    uart_transmitter_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                            .STOP_BITS(1), .FIFO_DEPTH(8)) u2 (
        .clk(clk), .reset(rst), .data_in(din[2]), .data_in_valid(vld[2]),
        .data_in_ready(rdy[2]), .serial_out(ser[2]), .tx_busy(bsy[2]), .fifo_count(cnt[2]));
    uart_transmitter_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0),
                            .STOP_BITS(2), .FIFO_DEPTH(8)) u3 (
        .clk(clk), .reset(rst), .data_in(din[3][6:0]), .data_in_valid(vld[3]),
        .data_in_ready(rdy[3]), .serial_out(ser[3]), .tx_busy(bsy[3]), .fifo_count(cnt[3]));

    function automatic int f_db(input int k);  return (k == 3) ? 7 : 8; endfunction
    function automatic int f_par(input int k); return (k == 1) ? 1 : (k == 2) ? 2 : 0; endfunction
    function automatic int f_sb(input int k);  return (k == 3) ? 2 : 1; endfunction
    function automatic int f_len(input int k);
        return (1 + f_db(k) + ((f_par(k) != 0) ? 1 : 0) + f_sb(k)) * T;
    endfunction

    // symbol i of the frame carrying word w; anything past the frame is line idle
    function automatic logic fbit(input int k, input int w, input int i);
        int d = f_db(k);
        if (i == 0) return 1'b0;
        if (i <= d) return 1'((w >> (i - 1)) & 1);
        if (f_par(k) != 0 && i == d + 1)
            return (f_par(k) == 1) ? 1'($countones(w) % 2) : 1'(1 - $countones(w) % 2);
        return 1'b1;
    endfunction

    // model: word queue, plus edges elapsed since the current frame was taken
    int fq [4][8];
    int head [4], size [4], since [4], word [4];
    bit act [4];

    always @(posedge clk or posedge rst) begin
        bit take;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                head[k] = 0; size[k] = 0; since[k] = 0; word[k] = 0; act[k] = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                take = vld[k] && size[k] < 8;
                if (act[k] && since[k] < f_len(k)) since[k]++;
                if ((!act[k] || since[k] == f_len(k)) && size[k] > 0) begin
                    word[k] = fq[k][head[k]];
                    head[k] = (head[k] + 1) % 8;
                    size[k]--;
                    since[k] = 0;
                    act[k] = 1;
                end
                if (take) begin
                    fq[k][(head[k] + size[k]) % 8] = int'(din[k]) & ((1 << f_db(k)) - 1);
                    size[k]++;
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, k, $time, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                chk("m_serial", k, ser[k],
                    (act[k] && since[k] >= 1) ? fbit(k, word[k], (since[k] - 1) / T) : 1'b1);
                chk("m_busy", k, bsy[k], (act[k] && since[k] < f_len(k)) || size[k] > 0);
                chk("m_count", k, cnt[k], size[k]);
                chk("m_ready", k, rdy[k], !rst && size[k] < 8);
            end
        end
    end

    task automatic goto(input int t);
        int n = 0;
        while (cyc < t && n < 5000) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic send(input logic [3:0] m);
        int n = 0;
        logic r;
        vld = m;
        do begin
            r = &(rdy | ~m);
            @(posedge clk); #1; n++;
        end while (!r && n < 400);
        vld = '0;
        chk("send_accepted", 0, r, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bsy != '0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_idle", 0, bsy, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [0:10] e0 = 11'b01010010111;
    logic [0:10] ee = 11'b01010010101;
    logic [0:10] eo = 11'b01010010111;
    logic [0:10] e3 = 11'b01000001111;
    int base;

    initial begin
        rst = 1'b1; vld = '0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        for (int k = 0; k < 4; k++) chk("ready_in_reset", k, rdy[k], 0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            chk("reset_serial", k, ser[k], 1);
            chk("reset_busy", k, bsy[k], 0);
            chk("reset_count", k, cnt[k], 0);
            chk("reset_ready", k, rdy[k], 1);
        end

        // single frames on all four variants
        din[0] = 8'hA5; din[1] = 8'hA5; din[2] = 8'hA5; din[3] = 8'h41;
        send(4'b1111);
        base = cyc;
        for (int i = 0; i < 10; i++) begin
            goto(base + 7 + 10 * i);
            chk("bit_8n1", 0, ser[0], e0[i]);
            chk("bit_8e1", 1, ser[1], ee[i]);
            chk("bit_8o1", 2, ser[2], eo[i]);
            chk("bit_7n2", 3, ser[3], e3[i]);
        end
        goto(base + 100);
        chk("busy_end_8n1", 0, bsy[0], 1);
        chk("busy_end_7n2", 3, bsy[3], 1);
        goto(base + 101);
        chk("idle_8n1", 0, bsy[0], 0);
        chk("idle_7n2", 3, bsy[3], 0);
        chk("busy_8e1", 1, bsy[1], 1);
        goto(base + 107);
        chk("stop_8e1", 1, ser[1], ee[10]);
        chk("stop_8o1", 2, ser[2], eo[10]);
        goto(base + 111);
        chk("idle_8e1", 1, bsy[1], 0);
        chk("idle_8o1", 2, bsy[2], 0);
        wait_idle();

        // push and pop on the same edge with three words queued
        din[0] = 8'h11; send(4'b0001);
        base = cyc;
        din[0] = 8'h22; send(4'b0001);
        din[0] = 8'h33; send(4'b0001);
        din[0] = 8'h44; send(4'b0001);
        chk("count_before", 0, cnt[0], 3);
        goto(base + 100);
        din[0] = 8'h55; send(4'b0001);
        chk("pushpop_count", 0, cnt[0], 3);
        wait_idle();

        // fill to full with valid held, then drain contiguous frames
        for (int d = 0; d < 10; d++) begin
            din[0] = 8'(d);
            send(4'b0001);
            if (d == 8) begin
                chk("full_count", 0, cnt[0], 8);
                chk("full_ready", 0, rdy[0], 0);
            end
        end
        wait_idle();

        // reset mid-frame with words queued
        din[0] = 8'h3C; send(4'b0001);
        base = cyc;
        din[0] = 8'h01; send(4'b0001);
        din[0] = 8'h02; send(4'b0001);
        din[0] = 8'h03; send(4'b0001);
        goto(base + 7 + 40);
        rst = 1'b1;
        #1;
        chk("midreset_serial", 0, ser[0], 1);
        chk("midreset_count", 0, cnt[0], 0);
        chk("midreset_busy", 0, bsy[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        din[0] = 8'h5A; send(4'b0001);
        base = cyc;
        goto(base + 7);
        chk("post_reset_start", 0, ser[0], 0);
        goto(base + 17);
        chk("post_reset_bit0", 0, ser[0], 0);
        goto(base + 27);
        chk("post_reset_bit1", 0, ser[0], 1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
